dadda_mul_sched: RTL

- Shares one combinational 32x32 multiplier core (dadda_multiplier class) between NUM_REQ requesters.
- Round-robin arbitration picks at most one request per cycle.
- Operands are registered into the core; the product is retimed through a fixed-latency pipeline.
- Each result is returned on one tagged valid/ready output with backpressure. The multiplier core sits outside this block; this block drives its operands and samples its product.

---
 rtl/dadda_mul_sched_pkg.sv | 19 +
 rtl/dadda_mul_sched_if.sv | 24 ++
 rtl/dadda_mul_sched_rr_arbiter.sv | 47 ++++
 rtl/dadda_mul_sched.sv | 117 +++++++++++
 4 files changed

// File: rtl/dadda_mul_sched_pkg.sv
// rtl/dadda_mul_sched_pkg.sv - shared defaults, id-width helper and pipeline stage type
package dadda_mul_sched_pkg;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_MUL_LAT = 2;
  localparam int MAX_ID_W    = 4;
  localparam int MAX_PROD_W  = 128;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Sized for the largest legal configuration; narrower builds zero-extend.
  typedef struct packed {
    logic                  valid;
    logic [MAX_ID_W-1:0]   id;
    logic [MAX_PROD_W-1:0] payload;
  } stage_t;
endpackage

// File: rtl/dadda_mul_sched_if.sv
// rtl/dadda_mul_sched_if.sv - requester and result handshake bundle
interface dadda_mul_sched_if import dadda_mul_sched_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ID_W    = id_width(NUM_REQ)
) ();
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     res_valid;
  logic                     res_ready;
  logic [2*WIDTH-1:0]       res_prod;
  logic [ID_W-1:0]          res_id;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_prod, res_id
  );
  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_prod, res_id
  );
endinterface

// File: rtl/dadda_mul_sched_rr_arbiter.sv
// rtl/dadda_mul_sched_rr_arbiter.sv - round-robin pointer and one-hot grant
module rr_arbiter import dadda_mul_sched_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               fire,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W:0]   idx;
  logic [ID_W-1:0] sel;
  logic            found;

  // Scan upward from the pointer, wrapping at NUM_REQ.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    sel      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      sel = idx[ID_W-1:0];
      if (en && !found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        grant_id   = sel;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (fire) ptr_d = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/dadda_mul_sched.sv
// rtl/dadda_mul_sched.sv - shares one external multiplier core between requesters
// Optional counters stat_ops/stat_stall under DADDA_MUL_SCHED_STATS_EN.
module dadda_mul_sched import dadda_mul_sched_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  dadda_mul_sched_if.slave     bus,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_prod
`ifdef DADDA_MUL_SCHED_STATS_EN
  ,
  output logic [31:0]          stat_ops,
  output logic [31:0]          stat_stall
`endif
);
  localparam int NS = MUL_LAT - 1;

  logic               stall, en, fire;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  stage_t             pipe_q [NS];
  stage_t             pipe_d [NS];
  logic               unused_last;

  assign stall         = bus.res_valid & ~bus.res_ready;
  assign en            = ~stall & ~rst;
  assign fire          = |(bus.req_valid & grant);
  assign bus.req_ready = grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.req_valid),
    .en       (en),
    .fire     (fire),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Operands keep their last value on idle cycles so the core does not toggle.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    pipe_d     = pipe_q;
    if (!stall) begin
      s1_valid_d = fire;
      if (fire) s1_id_d = grant_id;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          mul_a_d = bus.req_a[i*WIDTH +: WIDTH];
          mul_b_d = bus.req_b[i*WIDTH +: WIDTH];
        end
      end
      pipe_d[0].valid   = s1_valid_q;
      pipe_d[0].id      = MAX_ID_W'(s1_id_q);
      pipe_d[0].payload = MAX_PROD_W'(mul_prod);
      for (int j = 1; j < NS; j++) pipe_d[j] = pipe_q[j-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      for (int j = 0; j < NS; j++) pipe_q[j] <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      for (int j = 0; j < NS; j++) pipe_q[j] <= pipe_d[j];
    end
  end

  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;
  assign bus.res_valid = pipe_q[NS-1].valid;
  assign bus.res_prod  = pipe_q[NS-1].payload[2*WIDTH-1:0];
  assign bus.res_id    = pipe_q[NS-1].id[ID_W-1:0];
  assign unused_last   = ^pipe_q[NS-1];

`ifdef DADDA_MUL_SCHED_STATS_EN
  logic [31:0] stat_ops_q, stat_ops_d, stat_stall_q, stat_stall_d;

  always_comb begin
    stat_ops_d   = stat_ops_q;
    stat_stall_d = stat_stall_q;
    if (fire && (stat_ops_q != '1))    stat_ops_d   = stat_ops_q + 32'd1;
    if (stall && (stat_stall_q != '1)) stat_stall_d = stat_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_ops_q   <= stat_ops_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_ops   = stat_ops_q;
  assign stat_stall = stat_stall_q;
`endif
endmodule
